conv_window_gen: RTL and testbench

//  Sliding-window generator feeding the conv datapath. Accepts a raster-order pixel stream (32-bit

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 48 ++++
 rtl/conv_window_gen.sv | 154 +++++++++++++++
 tb/tb_conv_window_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution window generator.
// Pixels are 32-bit sign-magnitude Q15.16 and are carried without interpretation.
package conv_pkg;

  localparam int CONV_DW   = 32;
  localparam int FRAC_BITS = 16;
  localparam int CONV_K    = 7;

  // Flat window index of element (r, c); r=0 is the oldest row, c=0 the leftmost column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of delay: dout_o is the pixel written DEPTH enables ago.
// Circular buffer with a read-before-write slot; storage is deliberately unreset.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DW    = CONV_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  localparam int PW = coord_w(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // NOTE: the storage array has no reset; every slot is rewritten before it is ever read out.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KxK window generator over a raster pixel stream, one-deep registered output.
// Optional CONV_WIN_SOF_EN adds in_sof, which resynchronises the raster counters to (0,0).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int K     = CONV_K,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int DW    = CONV_DW,
  localparam int RW   = coord_w(IMG_H),
  localparam int CW   = coord_w(IMG_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
`ifdef CONV_WIN_SOF_EN
  input  logic              in_sof,
`endif
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output logic [RW-1:0]     win_row,
  output logic [CW-1:0]     win_col,
  output logic              frame_done
);

  logic [RW-1:0] row_q, row_d, pos_row;
  logic [CW-1:0] col_q, col_d, pos_col;
  logic          sof;
  logic          accept;
  logic          win_pos;
  logic          last_pix;

  logic [DW-1:0] lb_out [K-1];
  logic [DW-1:0] win_q  [K][K];
  logic [DW-1:0] win_d  [K][K];
  logic [K*K*DW-1:0] win_flat;

  logic              win_valid_q;
  logic [K*K*DW-1:0] win_data_q;
  logic [RW-1:0]     win_row_q;
  logic [CW-1:0]     win_col_q;
  logic              frame_done_q;

`ifdef CONV_WIN_SOF_EN
  assign sof = in_sof;
`else
  assign sof = 1'b0;
`endif

  // The output register frees up in the same cycle it is consumed, so no bubbles.
  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready;

  assign pos_row  = sof ? '0 : row_q;
  assign pos_col  = sof ? '0 : col_q;
  assign win_pos  = (pos_row >= RW'(K - 1)) && (pos_col >= CW'(K - 1));
  assign last_pix = (pos_row == RW'(IMG_H - 1)) && (pos_col == CW'(IMG_W - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (accept) begin
      if (pos_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (pos_row == RW'(IMG_H - 1)) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  // lb_out[j] carries the pixel from j+1 rows above the current one.
  for (genvar j = 0; j < K - 1; j++) begin : g_lines
    if (j == 0) begin : g_head
      conv_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .din_i  (in_data),
        .dout_o (lb_out[j])
      );
    end else begin : g_tail
      conv_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_line (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (accept),
        .din_i  (lb_out[j-1]),
        .dout_o (lb_out[j])
      );
    end
  end

  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < K - 1; r++) begin
      win_d[r][K-1] = lb_out[K-2-r];
    end
    win_d[K-1][K-1] = in_data;
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_flat[win_idx(r, c, K)*DW +: DW] = win_d[r][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      frame_done_q <= accept && last_pix;
      if (accept && win_pos) begin
        win_valid_q <= 1'b1;
        win_data_q  <= win_flat;
        win_row_q   <= pos_row - RW'(K - 1);
        win_col_q   <= pos_col - CW'(K - 1);
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen at K=3, 5x4 image; pixel(r,c) = (r*16+c)<<16.
module tb_conv_window_gen;

  localparam int K     = 3;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int DW    = 32;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int WB    = K * K * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          win_valid;
  logic          win_ready;
  logic [WB-1:0] win_data;
  logic [1:0]    win_row;
  logic [2:0]    win_col;
  logic          frame_done;
`ifdef CONV_WIN_SOF_EN
  logic          in_sof;
`endif

  int checks = 0;
  int errors = 0;

  logic          took;
  logic          cap_in_ready;
  logic [WB-1:0] cap_data;
  logic [1:0]    cap_row;
  logic [2:0]    cap_col;
  int            fd_cnt;

  int            acc_at [16];
  logic [WB-1:0] first_data, last_data;
  logic [1:0]    last_row;
  logic [2:0]    last_col;

  conv_window_gen #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef CONV_WIN_SOF_EN
    .in_sof     (in_sof),
`endif
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'((r * 16 + c) << 16);
  endfunction

  function automatic logic [WB-1:0] exp_win(input int wr, input int wc);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w[(r*K+c)*DW +: DW] = pix(wr + r, wc + c);
      end
    end
    return w;
  endfunction

  // Drive one cycle at the falling edge, capture outputs, then step past the rising edge.
  task automatic tick(input logic v, input logic [DW-1:0] d, input logic rdy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    win_ready = rdy;
    #1;
    acc          = v && in_ready;
    took         = win_valid && rdy;
    cap_in_ready = in_ready;
    cap_data     = win_data;
    cap_row      = win_row;
    cap_col      = win_col;
    if (frame_done) fd_cnt++;
    @(posedge clk);
    #1;
  endtask

  // Streams nframes back-to-back frames, optionally stalling the first window.
  task automatic stream_frames(input int nframes, input int stall, output int got);
    int            i, k, lk, stall_left, stall_seen;
    logic          acc, rdy;
    logic [WB-1:0] held;
    i = 0; k = 0; stall_left = stall; stall_seen = 0; held = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy = !(stall_left > 0 && win_valid);
      tick(i < nframes * NPIX, pix((i % NPIX) / IMG_W, i % IMG_W), rdy, acc);
      if (!rdy) begin
        checks++;
        if (cap_in_ready !== 1'b0 || acc) begin
          errors++;
          $display("FAIL stall_in_ready: got %b expected 0", cap_in_ready);
        end
        if (stall_seen == 0) begin
          held = cap_data;
        end else begin
          checks++;
          if (cap_data !== held) begin
            errors++;
            $display("FAIL stall_data_stable: got %h expected %h", cap_data, held);
          end
        end
        stall_seen++;
        stall_left--;
      end
      if (took) begin
        lk = k % 6;
        checks++;
        if (cap_row !== 2'(lk / 3) || cap_col !== 3'(lk % 3) || cap_data !== exp_win(lk / 3, lk % 3)) begin
          errors++;
          $display("FAIL window_%0d: got row %0d col %0d data %h expected row %0d col %0d data %h",
                   k, cap_row, cap_col, cap_data, lk / 3, lk % 3, exp_win(lk / 3, lk % 3));
        end
        if (k < 16) acc_at[k] = i;
        if (k == 0) first_data = cap_data;
        last_data = cap_data;
        last_row  = cap_row;
        last_col  = cap_col;
        k++;
      end
      if (acc) i++;
      if (i == nframes * NPIX && !win_valid) break;
    end
    checks++;
    if (i != nframes * NPIX || win_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_timeout: got %0d pixels expected %0d", i, nframes * NPIX);
    end
    got = k;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    win_ready = 1'b0;
    #1;
    checks++;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int got;
    fd_cnt = 0;
    stream_frames(1, 0, got);
    checks++;
    if (got != 6) begin errors++; $display("FAIL stream_count: got %0d expected 6", got); end
    checks++;
    if (acc_at[0] != 13) begin errors++; $display("FAIL stream_first_latency: got %0d expected 13", acc_at[0]); end
    checks++;
    if (first_data[0 +: 32] !== 32'h0000_0000) begin errors++; $display("FAIL first_elem0: got %h expected 00000000", first_data[0 +: 32]); end
    checks++;
    if (first_data[4*32 +: 32] !== 32'h0011_0000) begin errors++; $display("FAIL first_elem4: got %h expected 00110000", first_data[4*32 +: 32]); end
    checks++;
    if (first_data[8*32 +: 32] !== 32'h0022_0000) begin errors++; $display("FAIL first_elem8: got %h expected 00220000", first_data[8*32 +: 32]); end
    checks++;
    if (last_row !== 2'd1 || last_col !== 3'd2) begin errors++; $display("FAIL last_pos: got %0d,%0d expected 1,2", last_row, last_col); end
    checks++;
    if (last_data[8*32 +: 32] !== 32'h0034_0000) begin errors++; $display("FAIL last_elem8: got %h expected 00340000", last_data[8*32 +: 32]); end
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL stream_frame_done: got %0d expected 1", fd_cnt); end
  endtask

  task automatic test_backpressure();
    int got;
    stream_frames(1, 5, got);
    checks++;
    if (got != 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got); end
  endtask

  task automatic test_back_to_back();
    int got;
    fd_cnt = 0;
    stream_frames(2, 0, got);
    checks++;
    if (got != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", got); end
    checks++;
    if (fd_cnt != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d expected 2", fd_cnt); end
    checks++;
    if (acc_at[6] != 33) begin errors++; $display("FAIL b2b_frame2_first: got %0d expected 33", acc_at[6]); end
    checks++;
    if (first_data[8*32 +: 32] !== 32'h0022_0000) begin errors++; $display("FAIL b2b_elem8: got %h expected 00220000", first_data[8*32 +: 32]); end
  endtask

  task automatic test_midframe_reset();
    int   i, got;
    logic acc;
    i = 0;
    for (int cyc = 0; cyc < 50 && i < 14; cyc++) begin
      tick(1'b1, pix(i / IMG_W, i % IMG_W), 1'b1, acc);
      if (acc) i++;
    end
    tick(1'b0, '0, 1'b0, acc);
    checks++;
    if (win_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_pending: got %b expected 1", win_valid); end
    rst_n = 1'b0;
    tick(1'b0, '0, 1'b0, acc);
    rst_n = 1'b1;
    checks++;
    if (win_valid !== 1'b0) begin errors++; $display("FAIL midreset_win_valid: got %b expected 0", win_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    stream_frames(1, 0, got);
    checks++;
    if (got != 6) begin errors++; $display("FAIL midreset_count: got %0d expected 6", got); end
    checks++;
    if (acc_at[0] != 13) begin errors++; $display("FAIL midreset_first_latency: got %0d expected 13", acc_at[0]); end
  endtask

`ifdef CONV_WIN_SOF_EN
  task automatic test_sof();
    int            i, first_at;
    logic          acc;
    logic [WB-1:0] w;
    logic [1:0]    r0;
    logic [2:0]    c0;
    i = 0; first_at = -1; w = '0; r0 = '1; c0 = '1;
    for (int cyc = 0; cyc < 60 && i <= NPIX; cyc++) begin
      in_sof = (i == 7);
      tick(i < NPIX, pix(i / IMG_W, i % IMG_W), 1'b1, acc);
      if (took && first_at < 0) begin
        first_at = i; w = cap_data; r0 = cap_row; c0 = cap_col;
      end
      if (acc) i++;
      if (i == NPIX && first_at >= 0) break;
    end
    in_sof = 1'b0;
    checks++;
    if (first_at != 20) begin errors++; $display("FAIL sof_first_latency: got %0d expected 20", first_at); end
    checks++;
    if (r0 !== 2'd0 || c0 !== 3'd0) begin errors++; $display("FAIL sof_pos: got %0d,%0d expected 0,0", r0, c0); end
    checks++;
    if (w[0 +: 32] !== pix(1, 2) || w[8*32 +: 32] !== pix(3, 4)) begin
      errors++;
      $display("FAIL sof_elems: got %h,%h expected %h,%h", w[0 +: 32], w[8*32 +: 32], pix(1, 2), pix(3, 4));
    end
    rst_n = 1'b0;
    tick(1'b0, '0, 1'b1, acc);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    win_ready = 1'b0;
    fd_cnt    = 0;
`ifdef CONV_WIN_SOF_EN
    in_sof    = 1'b0;
`endif
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_midframe_reset();
`ifdef CONV_WIN_SOF_EN
    test_sof();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
